pulse_peak_detector: RTL and testbench
======================================

PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

Interface
REQ-001 Parameters SHALL be, one per line:
- DW, 20, sample width; matches the filtered FIR output.
- HYST, 256, hysteresis in LSBs for peak/trough qualification.
- MIN_GAP, 64, refractory interval in samples; a peak closer than this to the last accepted peak is rejected.
- TMO, 2047, sample count without an accepted peak before no_pulse asserts.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK_Filter  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-high.
- sample_valid  in  1  one-cycle strobe marking a new filtered sample.
- Filtered_In  in  DW  unsigned filtered sample from the FIR stage.
- beat  out  1  one-cycle pulse per accepted peak.
- period  out  16  samples between the last two accepted peaks.
- peak_val  out  DW  value of the last accepted peak.
- trough_val  out  DW  value of the last qualified trough.
- amplitude  out  DW  peak_val minus trough_val, floored at 0.
- no_pulse  out  1  timeout flag.

Function
REQ-003 The block SHALL act only on cycles with sample_valid=1; with sample_valid=0, all state and outputs hold, and beat=0.
REQ-004 The FSM SHALL have three states: IDLE, RISING, FALLING; IDLE is the reset state.
REQ-005 IDLE, on a valid sample: run_max=run_min=sample, gap=0, first=1; go to RISING.
REQ-006 RISING, sample > run_max: run_max=sample.
REQ-007 RISING, peak qualification:
- Condition: run_max - sample >= HYST and gap >= MIN_GAP, or first=1.
- Action: accept the peak, set run_min=sample, go to FALLING.
REQ-008 RISING, drop >= HYST with gap < MIN_GAP and first=0: reject the peak, stay in RISING, keep run_max unchanged.
REQ-009 Accepted peak with first=0, at the same clock edge:
- beat=1.
- period=gap.
- peak_val=run_max.
- amplitude=run_max-trough_val, floored at 0.
- gap=0 and no_pulse=0.
REQ-010 Accepted peak with first=1:
- beat stays 0; period and peak_val are unchanged.
- gap=0, first=0.
REQ-011 FALLING, sample < run_min: run_min=sample.
REQ-012 FALLING, sample - run_min >= HYST: trough_val=run_min, run_max=sample, go to RISING.
REQ-013 gap counter:
- Increments by 1 per valid sample.
- Saturates at 16'hFFFF.
REQ-014 When gap reaches TMO: no_pulse=1, first=1, FSM goes to IDLE; no_pulse holds until the next beat.
REQ-015 If timeout and peak acceptance fall on the same sample, the peak SHALL win; no timeout occurs.
REQ-016 Latency: beat and all value outputs SHALL update on the edge that samples the qualifying sample_valid, visible the following cycle; beat is high for exactly one cycle.
REQ-017 Arithmetic: all comparisons and differences SHALL be evaluated at DW+1 bits; no wrap-around at full scale.

Reset
REQ-018 rst_n=1 SHALL asynchronously clear every output, run_max, run_min and gap to 0, set first=1 and state=IDLE, regardless of the current state.
REQ-019 After rst_n deasserts, the first valid sample SHALL be treated as in REQ-005.

Structure
REQ-020 The shared package pulse_pkg SHALL hold the FSM state enum and the DW/HYST/MIN_GAP/TMO defaults.
REQ-021 One sub-module, pulse_gap_counter, SHALL implement the saturating 16-bit gap counter with clear input and timeout compare; the FSM and datapath live in the top module.

Verification
REQ-022 Reset mid-FALLING, pulse rst_n for 1 cycle -> all outputs 0, state IDLE, next sample reinitialises per REQ-005.
REQ-023 Triangle 0..10000, period 200 samples, valid every cycle:
- First peak: no beat.
- Each later peak: beat with period=200, peak_val=10000, trough_val=0, amplitude=10000.
REQ-024 Ripple ±100 around 5000 -> beat never asserts; no_pulse=1 after sample 2047; then a 0..10000 triangle -> first peak silent, next peak beat with no_pulse=0.
REQ-025 Peaks at sample 200, 240 (drop 1000) and 400 ->
- Peak at 240 rejected.
- Beat at 400 with period=200.
REQ-026 Full scale: 20'hFFFFF, then falling to 0, then rising to 20'hFFFFF, then falling -> peak_val=20'hFFFFF, amplitude=20'hFFFFF, no overflow.
REQ-027 sample_valid every 4th cycle with the 200-sample triangle -> period=200, not 800; beat 1 cycle wide.

Source files
------------

// File: rtl/pulse_peak_detector_pkg.sv
// ---------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the pulse peak detector slice.
//   - pd_state_t   : detector FSM states (IDLE is the reset state)
//   - *_DEF        : default sample width, hysteresis, refractory gap, timeout
//   - GAP_W        : width of the inter-peak sample counter
// ---------------------------------------------------------------------------
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } pd_state_t;

    localparam int DW_DEF      = 20;
    localparam int HYST_DEF    = 256;
    localparam int MIN_GAP_DEF = 64;
    localparam int TMO_DEF     = 2047;

    localparam int GAP_W       = 16;

endpackage

// File: rtl/pulse_peak_detector_if.sv
// ---------------------------------------------------------------------------
// pulse_peak_detector_if
// Sample stream in, beat/measurement results out.
//   sample_valid : one-cycle strobe marking a new filtered sample
//   Filtered_In  : unsigned filtered sample (DW bits)
//   beat         : one-cycle pulse per accepted peak
//   period       : samples between the last two accepted peaks
//   peak_val     : value of the last accepted peak
//   trough_val   : value of the last qualified trough
//   amplitude    : peak_val - trough_val, floored at 0
//   no_pulse     : timeout flag
// Modports: master = sample source / result consumer, slave = detector.
// ---------------------------------------------------------------------------
interface pulse_peak_detector_if
    import pulse_pkg::*;
#(
    parameter int DW = DW_DEF
);

    logic                sample_valid;
    logic [DW-1:0]       Filtered_In;
    logic                beat;
    logic [GAP_W-1:0]    period;
    logic [DW-1:0]       peak_val;
    logic [DW-1:0]       trough_val;
    logic [DW-1:0]       amplitude;
    logic                no_pulse;

    modport master (
        output sample_valid,
        output Filtered_In,
        input  beat,
        input  period,
        input  peak_val,
        input  trough_val,
        input  amplitude,
        input  no_pulse
    );

    modport slave (
        input  sample_valid,
        input  Filtered_In,
        output beat,
        output period,
        output peak_val,
        output trough_val,
        output amplitude,
        output no_pulse
    );

endinterface

// File: rtl/pulse_gap_counter.sv
// ---------------------------------------------------------------------------
// pulse_gap_counter
// Saturating count of valid samples since the last accepted peak.
//   CLK_Filter : clock
//   rst_n      : asynchronous, active-high reset (count -> 0)
//   enable     : advance on this cycle (a valid sample arrived)
//   clear      : with enable, restart the count at 0
//   gap_cur    : gap including the current sample (stored count + 1, saturated)
//   timeout    : gap_cur has reached TMO
// ---------------------------------------------------------------------------
module pulse_gap_counter
    import pulse_pkg::*;
#(
    parameter int TMO = TMO_DEF
) (
    input  logic             CLK_Filter,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    output logic [GAP_W-1:0] gap_cur,
    output logic             timeout
);

    localparam logic [GAP_W-1:0] GAP_MAX = '1;
    localparam logic [GAP_W-1:0] TMO_G   = GAP_W'(TMO);

    logic [GAP_W-1:0] gap_q;

    // The detector reasons about the gap "as of" the sample being processed,
    // so expose the incremented value combinationally; it never wraps past
    // all-ones.
    always_comb begin
        gap_cur = (gap_q == GAP_MAX) ? gap_q : gap_q + 16'd1;
        timeout = (gap_cur >= TMO_G);
    end

    // Counter register: moves only on valid samples; clear wins over count.
    always_ff @(posedge CLK_Filter or posedge rst_n) begin
        if (rst_n) begin
            gap_q <= '0;
        end else if (enable) begin
            gap_q <= clear ? '0 : gap_cur;
        end
    end

endmodule

// File: rtl/pulse_peak_detector.sv
// ---------------------------------------------------------------------------
// pulse_peak_detector
// Hysteresis-based peak/trough tracker for a filtered pulse waveform.
// A peak is accepted once the signal has dropped HYST below its running
// maximum, provided at least MIN_GAP samples have passed since the previous
// accepted peak (the very first peak after start-up/timeout is accepted
// silently to establish a time reference). A trough is qualified once the
// signal has risen HYST above its running minimum.
//   CLK_Filter : clock
//   rst_n      : asynchronous, active-high reset
//   pp         : slave side of pulse_peak_detector_if (samples in, results out)
// ---------------------------------------------------------------------------
module pulse_peak_detector
    import pulse_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int HYST    = HYST_DEF,
    parameter int MIN_GAP = MIN_GAP_DEF,
    parameter int TMO     = TMO_DEF
) (
    input  logic                  CLK_Filter,
    input  logic                  rst_n,
    pulse_peak_detector_if.slave  pp
);

    localparam logic [DW:0]      HYST_X    = (DW+1)'(HYST);
    localparam logic [GAP_W-1:0] MIN_GAP_G = GAP_W'(MIN_GAP);

    pd_state_t        state_q, state_d;

    logic [DW-1:0]    run_max_q, run_max_d;
    logic [DW-1:0]    run_min_q, run_min_d;
    logic             first_q, first_d;

    logic             beat_q, beat_d;
    logic [GAP_W-1:0] period_q, period_d;
    logic [DW-1:0]    peak_val_q, peak_val_d;
    logic [DW-1:0]    trough_val_q, trough_val_d;
    logic [DW-1:0]    amplitude_q, amplitude_d;
    logic             no_pulse_q, no_pulse_d;

    logic [GAP_W-1:0] gap_cur;
    logic             gap_timeout;
    logic             gap_clear;

    logic             accept;
    logic             trough_hit;
    logic             timeout_hit;

    logic [DW:0]      sample_x, max_x, min_x;
    logic             drop_ok, rise_ok, gap_ok;
    logic [DW-1:0]    amp_calc;

    pulse_gap_counter #(
        .TMO (TMO)
    ) u_gap (
        .CLK_Filter (CLK_Filter),
        .rst_n      (rst_n),
        .enable     (pp.sample_valid),
        .clear      (gap_clear),
        .gap_cur    (gap_cur),
        .timeout    (gap_timeout)
    );

    // Comparisons carry one extra bit so that "x + HYST" near full scale
    // cannot wrap and fake a qualifying drop or rise.
    always_comb begin
        sample_x = {1'b0, pp.Filtered_In};
        max_x    = {1'b0, run_max_q};
        min_x    = {1'b0, run_min_q};
        drop_ok  = (max_x >= (sample_x + HYST_X));
        rise_ok  = (sample_x >= (min_x + HYST_X));
        gap_ok   = (gap_cur >= MIN_GAP_G);
        amp_calc = (run_max_q >= trough_val_q) ? (run_max_q - trough_val_q) : '0;
    end

    // State register.
    always_ff @(posedge CLK_Filter or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Nothing moves without a valid sample. A peak being
    // accepted on the same sample as the timeout takes priority, so RISING
    // checks acceptance first. In FALLING the timeout dominates a trough.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        trough_hit  = 1'b0;
        timeout_hit = 1'b0;
        gap_clear   = 1'b0;
        if (pp.sample_valid) begin
            case (state_q)
                IDLE: begin
                    gap_clear = 1'b1;
                    state_d   = RISING;
                end
                RISING: begin
                    if (drop_ok && (gap_ok || first_q)) begin
                        accept    = 1'b1;
                        gap_clear = 1'b1;
                        state_d   = FALLING;
                    end else if (gap_timeout) begin
                        timeout_hit = 1'b1;
                        state_d     = IDLE;
                    end
                end
                FALLING: begin
                    if (gap_timeout) begin
                        timeout_hit = 1'b1;
                        state_d     = IDLE;
                    end else if (rise_ok) begin
                        trough_hit = 1'b1;
                        state_d    = RISING;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output/datapath logic. Everything holds by default; beat defaults low
    // so it lasts exactly one cycle. A rejected peak (drop seen too soon)
    // simply leaves run_max alone so the same maximum is re-tested later.
    always_comb begin
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        first_d      = first_q;
        beat_d       = 1'b0;
        period_d     = period_q;
        peak_val_d   = peak_val_q;
        trough_val_d = trough_val_q;
        amplitude_d  = amplitude_q;
        no_pulse_d   = no_pulse_q;
        if (pp.sample_valid) begin
            case (state_q)
                IDLE: begin
                    run_max_d = pp.Filtered_In;
                    run_min_d = pp.Filtered_In;
                    first_d   = 1'b1;
                end
                RISING: begin
                    if (sample_x > max_x) begin
                        run_max_d = pp.Filtered_In;
                    end
                    if (accept) begin
                        run_min_d = pp.Filtered_In;
                        first_d   = 1'b0;
                        if (!first_q) begin
                            beat_d      = 1'b1;
                            period_d    = gap_cur;
                            peak_val_d  = run_max_q;
                            amplitude_d = amp_calc;
                            no_pulse_d  = 1'b0;
                        end
                    end
                end
                FALLING: begin
                    if (sample_x < min_x) begin
                        run_min_d = pp.Filtered_In;
                    end
                    if (trough_hit) begin
                        trough_val_d = run_min_q;
                        run_max_d    = pp.Filtered_In;
                    end
                end
                default: begin
                    first_d = 1'b1;
                end
            endcase
            if (timeout_hit) begin
                no_pulse_d = 1'b1;
                first_d    = 1'b1;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK_Filter or posedge rst_n) begin
        if (rst_n) begin
            run_max_q    <= '0;
            run_min_q    <= '0;
            first_q      <= 1'b1;
            beat_q       <= 1'b0;
            period_q     <= '0;
            peak_val_q   <= '0;
            trough_val_q <= '0;
            amplitude_q  <= '0;
            no_pulse_q   <= 1'b0;
        end else begin
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            first_q      <= first_d;
            beat_q       <= beat_d;
            period_q     <= period_d;
            peak_val_q   <= peak_val_d;
            trough_val_q <= trough_val_d;
            amplitude_q  <= amplitude_d;
            no_pulse_q   <= no_pulse_d;
        end
    end

    assign pp.beat       = beat_q;
    assign pp.period     = period_q;
    assign pp.peak_val   = peak_val_q;
    assign pp.trough_val = trough_val_q;
    assign pp.amplitude  = amplitude_q;
    assign pp.no_pulse   = no_pulse_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// ---------------------------------------------------------------------------
// tb_pulse_peak_detector
// Directed bench for pulse_peak_detector. Expected beats are queued when the
// qualifying sample is driven and popped when that sample has been clocked.
// ---------------------------------------------------------------------------
module tb_pulse_peak_detector;
    import pulse_pkg::*;

    localparam int DW = 20;

    typedef struct {
        int               idx;
        logic [15:0]      period;
        logic [DW-1:0]    peak;
        logic [DW-1:0]    trough;
        logic [DW-1:0]    amp;
    } exp_beat_t;

    logic CLK_Filter = 1'b0;
    logic rst_n;

    int total = 0;
    int bad   = 0;
    int sidx  = 0;

    exp_beat_t     exp_q[$];
    logic [15:0]   last_period;
    logic [DW-1:0] last_peak;

    pulse_peak_detector_if #(.DW(DW)) pif ();

    pulse_peak_detector #(
        .DW      (DW),
        .HYST    (256),
        .MIN_GAP (64),
        .TMO     (2047)
    ) dut (
        .CLK_Filter (CLK_Filter),
        .rst_n      (rst_n),
        .pp         (pif.slave)
    );

    // 100 MHz sample clock.
    always #5 CLK_Filter = ~CLK_Filter;

    // One comparison: counts it and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushBeat(input int idx, input logic [15:0] per, input logic [DW-1:0] pk,
                            input logic [DW-1:0] tr, input logic [DW-1:0] am);
        exp_q.push_back('{idx: idx, period: per, peak: pk, trough: tr, amp: am});
    endtask

    // Drive one cycle; on valid samples check beat against the scoreboard,
    // on idle cycles check that beat stays low and results hold.
    task automatic applyStimulus(input logic valid, input logic [DW-1:0] value);
        exp_beat_t e;
        logic      exp_beat;
        @(negedge CLK_Filter);
        pif.sample_valid = valid;
        pif.Filtered_In  = value;
        @(posedge CLK_Filter);
        #1;
        if (valid) begin
            exp_beat = (exp_q.size() > 0) && (exp_q[0].idx == sidx);
            checkOutput("beat", 32'(pif.beat), 32'(exp_beat));
            if (exp_beat) begin
                e = exp_q.pop_front();
                checkOutput("period",     32'(pif.period),     32'(e.period));
                checkOutput("peak_val",   32'(pif.peak_val),   32'(e.peak));
                checkOutput("trough_val", 32'(pif.trough_val), 32'(e.trough));
                checkOutput("amplitude",  32'(pif.amplitude),  32'(e.amp));
                checkOutput("no_pulse_at_beat", 32'(pif.no_pulse), 32'd0);
                last_period = e.period;
                last_peak   = e.peak;
            end
            sidx++;
        end else begin
            checkOutput("beat_idle",     32'(pif.beat),     32'd0);
            checkOutput("period_hold",   32'(pif.period),   32'(last_period));
            checkOutput("peak_val_hold", 32'(pif.peak_val), 32'(last_peak));
        end
    endtask

    // One-cycle reset pulse, with outputs checked while reset is asserted
    // (before any clock edge) so the asynchronous clear is exercised.
    task automatic resetPulse();
        @(negedge CLK_Filter);
        rst_n            = 1'b1;
        pif.sample_valid = 1'b0;
        pif.Filtered_In  = '0;
        #2;
        checkOutput("rst_beat",       32'(pif.beat),       32'd0);
        checkOutput("rst_period",     32'(pif.period),     32'd0);
        checkOutput("rst_peak_val",   32'(pif.peak_val),   32'd0);
        checkOutput("rst_trough_val", 32'(pif.trough_val), 32'd0);
        checkOutput("rst_amplitude",  32'(pif.amplitude),  32'd0);
        checkOutput("rst_no_pulse",   32'(pif.no_pulse),   32'd0);
        checkOutput("rst_state",      32'(dut.state_q),    32'(IDLE));
        @(negedge CLK_Filter);
        rst_n       = 1'b0;
        sidx        = 0;
        last_period = '0;
        last_peak   = '0;
        exp_q.delete();
    endtask

    // 0..10000..0 triangle, 200 samples per period, peak at phase 100.
    function automatic logic [DW-1:0] tri_val(input int i);
        int p;
        p = i % 200;
        return (p <= 100) ? DW'(p * 100) : DW'((200 - p) * 100);
    endfunction

    // Peaks at 200 (accepted), 240 (too close, 1000 drop), 400 (accepted).
    function automatic logic [DW-1:0] step_wave(input int i);
        int v;
        if (i <= 200)      v = i * 50;
        else if (i <= 210) v = 10000 - (i - 200) * 100;
        else if (i <= 220) v = 9000 + (i - 210) * 100;
        else if (i <= 240) v = 10000;
        else if (i <= 250) v = 10000 - (i - 240) * 100;
        else if (i <= 260) v = 9000 + (i - 250) * 100;
        else if (i <= 400) v = 10000 + (i - 260) * 10;
        else               v = 11400 - (i - 400) * 100;
        return DW'(v);
    endfunction

    // Full-scale swing: top, down to 0, back to top, down again.
    function automatic logic [DW-1:0] full_wave(input int i);
        int v;
        if (i == 0)        v = 1048575;
        else if (i <= 64)  v = 1048575 - i * 16384;
        else if (i <= 128) v = (i - 64) * 16384;
        else               v = 1048575 - (i - 128) * 16384;
        if (v < 0)       v = 0;
        if (v > 1048575) v = 1048575;
        return DW'(v);
    endfunction

    initial begin
        rst_n            = 1'b1;
        pif.sample_valid = 1'b0;
        pif.Filtered_In  = '0;
        last_period      = '0;
        last_peak        = '0;
        repeat (2) @(posedge CLK_Filter);

        $display("[TB] reset state");
        resetPulse();

        $display("[TB] reset while FALLING");
        for (int i = 0; i <= 350; i++) begin
            if (i == 303) pushBeat(i, 16'd200, 20'd10000, 20'd0, 20'd10000);
            applyStimulus(1'b1, tri_val(i));
        end
        checkOutput("sb_drain_pre_reset", 32'(exp_q.size()), 32'd0);
        checkOutput("state_falling",      32'(dut.state_q),  32'(FALLING));
        resetPulse();

        $display("[TB] triangle, valid every cycle");
        for (int i = 0; i < 600; i++) begin
            if (i >= 303 && ((i - 303) % 200) == 0)
                pushBeat(i, 16'd200, 20'd10000, 20'd0, 20'd10000);
            applyStimulus(1'b1, tri_val(i));
        end
        checkOutput("sb_drain_tri", 32'(exp_q.size()), 32'd0);

        $display("[TB] ripple timeout then recovery");
        resetPulse();
        for (int i = 0; i <= 2047; i++) begin
            applyStimulus(1'b1, (i % 2 == 1) ? 20'd5100 : 20'd4900);
            if (i == 2046) checkOutput("no_pulse_before_tmo", 32'(pif.no_pulse), 32'd0);
            if (i == 2047) begin
                checkOutput("no_pulse_at_tmo", 32'(pif.no_pulse), 32'd1);
                checkOutput("state_after_tmo", 32'(dut.state_q),  32'(IDLE));
            end
        end
        sidx = 0;
        for (int j = 0; j < 400; j++) begin
            if (j == 303) pushBeat(j, 16'd200, 20'd10000, 20'd0, 20'd10000);
            applyStimulus(1'b1, tri_val(j));
            if (j == 302) checkOutput("no_pulse_held", 32'(pif.no_pulse), 32'd1);
        end
        checkOutput("no_pulse_cleared", 32'(pif.no_pulse), 32'd0);
        checkOutput("sb_drain_ripple",  32'(exp_q.size()), 32'd0);

        $display("[TB] refractory rejection");
        resetPulse();
        for (int i = 0; i <= 410; i++) begin
            if (i == 403) pushBeat(i, 16'd200, 20'd11400, 20'd9000, 20'd2400);
            applyStimulus(1'b1, step_wave(i));
        end
        checkOutput("sb_drain_refractory", 32'(exp_q.size()), 32'd0);

        $display("[TB] full scale");
        resetPulse();
        for (int i = 0; i <= 135; i++) begin
            if (i == 129) pushBeat(i, 16'd128, 20'hFFFFF, 20'd0, 20'hFFFFF);
            applyStimulus(1'b1, full_wave(i));
        end
        checkOutput("sb_drain_full", 32'(exp_q.size()), 32'd0);

        $display("[TB] hysteresis threshold");
        resetPulse();
        applyStimulus(1'b1, 20'd1000);
        applyStimulus(1'b1, 20'd745);
        checkOutput("drop_255_state", 32'(dut.state_q), 32'(RISING));
        applyStimulus(1'b1, 20'd744);
        checkOutput("drop_256_state", 32'(dut.state_q), 32'(FALLING));
        applyStimulus(1'b1, 20'd999);
        checkOutput("rise_255_state",  32'(dut.state_q),    32'(FALLING));
        checkOutput("rise_255_trough", 32'(pif.trough_val), 32'd0);
        applyStimulus(1'b1, 20'd1000);
        checkOutput("rise_256_state",  32'(dut.state_q),    32'(RISING));
        checkOutput("rise_256_trough", 32'(pif.trough_val), 32'd744);

        $display("[TB] triangle, valid every 4th cycle");
        resetPulse();
        for (int i = 0; i < 600; i++) begin
            if (i >= 303 && ((i - 303) % 200) == 0)
                pushBeat(i, 16'd200, 20'd10000, 20'd0, 20'd10000);
            applyStimulus(1'b1, tri_val(i));
            for (int k = 0; k < 3; k++) applyStimulus(1'b0, DW'($urandom));
        end
        checkOutput("sb_drain_sparse", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
